uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: receive FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_BITS, default 40: idle bit-periods before timeout (RX_TIMEOUT_EN only).
REQ-003 Port clk  in  1  system clock; all logic rising-edge.
REQ-004 Port arst_n  in  1  asynchronous active-low reset.
REQ-005 Port cfg_enable  in  1  host request to run the receiver.
REQ-006 Port cfg_baud_div  in  32  requested clk cycles per bit.
REQ-007 Port rd_en  in  1  host pop strobe, one entry per cycle.
REQ-008 Port clr_flags  in  1  clears overrun and err_cnt.
REQ-009 Port rx_en  out  1  to uart_rx enable.
REQ-010 Port baud_div  out  32  to uart_rx divider, active value.
REQ-011 Port rx_data_out, rx_busy, rx_done_tick, rx_error  in  8/1/1/1  from uart_rx.
REQ-012 Port rd_data  out  8  FIFO head, first-word-fall-through.
REQ-013 Port rd_valid  out  1  FIFO non-empty.
REQ-014 Port fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-015 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-016 Port overrun  out  1  sticky: good frame dropped on full FIFO.
REQ-017 Port err_cnt  out  8  saturating count of framing-error frames.
REQ-018 Port timeout_irq  out  1  sticky idle-timeout flag (0 when RX_TIMEOUT_EN undefined).

Function
REQ-019 States OFF, LOAD, RUN, STOP; the controller SHALL drive rx_en=1 only in RUN and STOP.
REQ-020 OFF->LOAD when cfg_enable=1; LOAD lasts one cycle and latches cfg_baud_div into baud_div; LOAD->RUN.
REQ-021 RUN->STOP when cfg_enable=0 and rx_busy=1; RUN->OFF when cfg_enable=0 and rx_busy=0.
REQ-022 STOP->OFF on the cycle after rx_done_tick or rx_busy=0; the completing frame SHALL be processed normally.
REQ-023 In RUN, cfg_baud_div != baud_div with rx_busy=0 SHALL cause RUN->LOAD (rx_en low one cycle); with rx_busy=1 the change is deferred until rx_busy=0.
REQ-024 cfg_baud_div=0 SHALL be treated as 1 when latched.
REQ-025 rx_done_tick with rx_error=0 SHALL push rx_data_out; with rx_error=1 SHALL drop the byte and increment err_cnt, saturating at 255.
REQ-026 Push on full FIFO without same-cycle pop SHALL drop the byte and set overrun.
REQ-027 Simultaneous push and pop on full FIFO SHALL succeed with no overrun; level unchanged.
REQ-028 rd_en with rd_valid=0 SHALL be ignored; rd_data value then undefined but stable.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; pushed byte visible on rd_data the cycle after rx_done_tick.
REQ-030 clr_flags SHALL clear overrun, err_cnt, timeout_irq; a same-cycle set event SHALL win.

Reset
REQ-031 arst_n=0 SHALL immediately force state OFF, rx_en=0, baud_div=0, FIFO empty (rd_valid=0, fifo_level=0, fifo_full=0), rd_data=0, overrun=0, err_cnt=0, timeout_irq=0, mid-frame or not.
REQ-032 After release, state SHALL be OFF until cfg_enable is sampled 1.

Configuration
REQ-033 Macro UART_RX_CTRL_TIMEOUT_EN defined: a bit-tick counter (period baud_div) SHALL count idle bit-periods while rd_valid=1 and rx_busy=0, restart on push, pop or rx_busy=1, and set timeout_irq on reaching TIMEOUT_BITS.
REQ-034 Macro undefined: no timeout counter is synthesised; timeout_irq tied 0.

Verification
REQ-035 Reset: arst_n low mid-frame with 3 bytes queued -> rx_en=0, rd_valid=0, fifo_level=0, err_cnt=0 same cycle.
REQ-036 Enable, cfg_baud_div=10416, send 0xA5 at 9600 baud -> baud_div=10416, rd_valid=1, rd_data=0xA5, fifo_level=1.
REQ-037 Frame 0x5A with stop bit 0 -> no push, err_cnt=1; 256 such frames -> err_cnt=255.
REQ-038 FIFO_DEPTH=8, 9 good bytes, no pops -> fifo_full=1, overrun=1, bytes 1-8 read back in order; pop on 9th push cycle -> overrun stays 0.
REQ-039 cfg_enable=0 and cfg_baud_div change mid-frame -> STOP, frame 0x3C still pushed, then OFF; divider update deferred until rx_busy=0.
REQ-040 UART_RX_CTRL_TIMEOUT_EN, 1 byte queued, line idle 40 bit-periods -> timeout_irq=1; clr_flags -> 0.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Host and uart_rx side signals of the receive controller.
// slave = controller view, master = host/peripheral view.
interface uart_rx_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          cfg_enable;
  logic [31:0]   cfg_baud_div;
  logic          rd_en;
  logic          clr_flags;
  logic          rx_en;
  logic [31:0]   baud_div;
  logic [7:0]    rx_data_out;
  logic          rx_busy;
  logic          rx_done_tick;
  logic          rx_error;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic [7:0]    err_cnt;
  logic          timeout_irq;

  modport slave (
    input  cfg_enable, cfg_baud_div, rd_en, clr_flags,
    input  rx_data_out, rx_busy, rx_done_tick, rx_error,
    output rx_en, baud_div, rd_data, rd_valid, fifo_full, fifo_level,
    output overrun, err_cnt, timeout_irq
  );

  modport master (
    output cfg_enable, cfg_baud_div, rd_en, clr_flags,
    output rx_data_out, rx_busy, rx_done_tick, rx_error,
    input  rx_en, baud_div, rd_data, rd_valid, fifo_full, fifo_level,
    input  overrun, err_cnt, timeout_irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable/divider sequencing, FWFT receive FIFO, error and overrun flags.
// Optional idle timeout enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input logic           clk,
  input logic           arst_n,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [1:0] StOff  = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StStop = 2'd3;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_BITS == 0) begin : g_bad_param
    $error("uart_rx_ctrl: illegal FIFO_DEPTH or TIMEOUT_BITS");
  end

  logic [1:0]    r_state, w_state_nxt;
  logic [31:0]   r_baud_div, w_cfg_div;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic [7:0]    r_err_cnt;
  logic          w_rx_en, w_full, w_valid, w_pop, w_frame;
  logic          w_push_req, w_push, w_ovr_set, w_err_evt;

  // A zero divider would stall uart_rx, so it is promoted to 1 before comparing or latching.
  assign w_cfg_div = (bus.cfg_baud_div == 32'd0) ? 32'd1 : bus.cfg_baud_div;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StOff:  if (bus.cfg_enable) w_state_nxt = StLoad;
      StLoad: w_state_nxt = StRun;
      StRun: begin
        if (!bus.cfg_enable) begin
          w_state_nxt = bus.rx_busy ? StStop : StOff;
        end else if (!bus.rx_busy && (w_cfg_div != r_baud_div)) begin
          w_state_nxt = StLoad;
        end
      end
      StStop: if (bus.rx_done_tick || !bus.rx_busy) w_state_nxt = StOff;
      default: w_state_nxt = StOff;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= StOff;
      r_baud_div <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StLoad) r_baud_div <= w_cfg_div;
    end
  end

  assign w_rx_en    = (r_state == StRun) || (r_state == StStop);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_valid    = (r_level != '0);
  assign w_pop      = bus.rd_en && w_valid;
  assign w_frame    = w_rx_en && bus.rx_done_tick;
  assign w_push_req = w_frame && !bus.rx_error;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovr_set  = w_push_req && w_full && !w_pop;
  assign w_err_evt  = w_frame && bus.rx_error;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
    end else if (w_push) begin
      r_mem[r_wptr] <= bus.rx_data_out;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Set events take priority over clr_flags; a cleared counter restarts at 1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_overrun <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (bus.clr_flags) r_overrun <= 1'b0;
      if (w_err_evt) begin
        if (bus.clr_flags)             r_err_cnt <= 8'd1;
        else if (r_err_cnt != 8'hFF)   r_err_cnt <= r_err_cnt + 8'd1;
      end else if (bus.clr_flags) begin
        r_err_cnt <= 8'd0;
      end
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_BITS + 1);

  logic [31:0]   r_tick_cnt;
  logic [IW-1:0] r_idle_bits;
  logic          r_timeout_irq;
  logic          w_restart, w_bit_tick, w_to_set;

  assign w_restart  = w_push || w_pop || bus.rx_busy || !w_valid;
  assign w_bit_tick = ({1'b0, r_tick_cnt} + 33'd1) >= {1'b0, r_baud_div};
  assign w_to_set   = !w_restart && w_bit_tick && (r_idle_bits == IW'(TIMEOUT_BITS - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tick_cnt    <= 32'd0;
      r_idle_bits   <= '0;
      r_timeout_irq <= 1'b0;
    end else begin
      if (w_restart) begin
        r_tick_cnt  <= 32'd0;
        r_idle_bits <= '0;
      end else if (w_bit_tick) begin
        r_tick_cnt <= 32'd0;
        if (r_idle_bits != IW'(TIMEOUT_BITS)) r_idle_bits <= r_idle_bits + IW'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + 32'd1;
      end
      if (w_to_set)           r_timeout_irq <= 1'b1;
      else if (bus.clr_flags) r_timeout_irq <= 1'b0;
    end
  end

  assign bus.timeout_irq = r_timeout_irq;
`else
  assign bus.timeout_irq = 1'b0;
`endif

  assign bus.rx_en      = w_rx_en;
  assign bus.baud_div   = r_baud_div;
  assign bus.rd_data    = r_mem[r_rptr];
  assign bus.rd_valid   = w_valid;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_level = r_level;
  assign bus.overrun    = r_overrun;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl; uart_rx is modelled at frame level (busy, done tick).
// Reference model: byte queue plus sticky flag/counter variables.
module tb_uart_rx_ctrl;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(40)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit         m_ovr;
  int         m_err;

  // Drive one cycle of stimulus at a negedge, advance the model, land on the next negedge.
  task automatic step(input bit done, input logic [7:0] data, input bit err, input bit busy,
                      input bit rd, input bit clr);
    bit pop_ok;
    bus.rx_done_tick = done;
    bus.rx_data_out  = data;
    bus.rx_error     = err;
    bus.rx_busy      = busy;
    bus.rd_en        = rd;
    bus.clr_flags    = clr;
    pop_ok = rd && (q.size() > 0);
    if (clr) begin
      m_ovr = 1'b0;
      m_err = 0;
    end
    if (done && err) m_err = (m_err < 255) ? m_err + 1 : 255;
    if (done && !err) begin
      if (q.size() < DEPTH || pop_ok) q.push_back(data);
      else m_ovr = 1'b1;
    end
    if (pop_ok) void'(q.pop_front());
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rd_en        = 1'b0;
    bus.clr_flags    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    bus.cfg_enable = 1'b0;
    bus.cfg_baud_div = 32'd0;
    bus.rd_en = 1'b0;
    bus.clr_flags = 1'b0;
    bus.rx_data_out = 8'h00;
    bus.rx_busy = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_error = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    idle(3);
    n_cmp += 9;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL reset_rx_en got %b want 0", bus.rx_en); end
    if (bus.baud_div !== 32'd0) begin n_fail++; $display("FAIL reset_baud got %0d want 0", bus.baud_div); end
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
    if (bus.fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
    if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", bus.err_cnt); end
    if (bus.timeout_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.timeout_irq); end
  endtask

  task automatic test_enable();
    bus.cfg_baud_div = 32'd10416;
    bus.cfg_enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL load_rx_en got %b want 0", bus.rx_en); end
    @(negedge clk);
    n_cmp += 2;
    if (bus.rx_en !== 1'b1) begin n_fail++; $display("FAIL run_rx_en got %b want 1", bus.rx_en); end
    if (bus.baud_div !== 32'd10416) begin n_fail++; $display("FAIL run_baud got %0d want 10416", bus.baud_div); end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp += 3;
    if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid got %b want 1", bus.rd_valid); end
    if (bus.rd_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h want a5", bus.rd_data); end
    if (bus.fifo_level !== 4'd1) begin n_fail++; $display("FAIL a5_level got %0d want 1", bus.fifo_level); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL a5_pop_valid got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_frame_error();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus.fifo_level !== 4'd0) begin n_fail++; $display("FAIL ferr_level got %0d want 0", bus.fifo_level); end
    if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL ferr_cnt1 got %0d want 1", bus.err_cnt); end
    for (int i = 0; i < 255; i++) step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL ferr_sat got %0d want 255", bus.err_cnt); end
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b want 0", bus.rd_valid); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL ferr_clr got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b [9];
    for (int i = 0; i < 9; i++) begin
      exp_b[i] = 8'($urandom);
      step(1'b1, exp_b[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_cmp += 3;
    if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b want 1", bus.fifo_full); end
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
    if (bus.fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovr_level got %0d want 8", bus.fifo_level); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.rd_data !== exp_b[i]) begin
        n_fail++; $display("FAIL ovr_order[%0d] got %h want %h", i, bus.rd_data, exp_b[i]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp += 3;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovr got %b want 0", bus.overrun); end
    if (bus.fifo_level !== 4'd8) begin n_fail++; $display("FAIL pushpop_level got %0d want 8", bus.fifo_level); end
    if (bus.rd_data !== q[0]) begin n_fail++; $display("FAIL pushpop_head got %h want %h", bus.rd_data, q[0]); end
    while (q.size() > 0) begin
      n_cmp++;
      if (bus.rd_data !== q[0]) begin n_fail++; $display("FAIL pushpop_drain got %h want %h", bus.rd_data, q[0]); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_divider_defer();
    bus.cfg_baud_div = 32'd5000;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus.rx_en !== 1'b1) begin n_fail++; $display("FAIL defer_rx_en got %b want 1", bus.rx_en); end
    if (bus.baud_div !== 32'd10416) begin n_fail++; $display("FAIL defer_baud got %0d want 10416", bus.baud_div); end
    idle(1);
    n_cmp++;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL reload_rx_en got %b want 0", bus.rx_en); end
    idle(1);
    n_cmp += 2;
    if (bus.rx_en !== 1'b1) begin n_fail++; $display("FAIL reload_run got %b want 1", bus.rx_en); end
    if (bus.baud_div !== 32'd5000) begin n_fail++; $display("FAIL reload_baud got %0d want 5000", bus.baud_div); end
    bus.cfg_baud_div = 32'd0;
    idle(4);
    n_cmp += 2;
    if (bus.baud_div !== 32'd1) begin n_fail++; $display("FAIL zero_baud got %0d want 1", bus.baud_div); end
    if (bus.rx_en !== 1'b1) begin n_fail++; $display("FAIL zero_stable got %b want 1", bus.rx_en); end
    bus.cfg_baud_div = 32'd10416;
    idle(2);
  endtask

  task automatic test_stop();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.cfg_enable = 1'b0;
    bus.cfg_baud_div = 32'd7777;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus.rx_en !== 1'b1) begin n_fail++; $display("FAIL stop_rx_en got %b want 1", bus.rx_en); end
    if (bus.baud_div !== 32'd10416) begin n_fail++; $display("FAIL stop_baud got %0d want 10416", bus.baud_div); end
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp += 3;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL off_rx_en got %b want 0", bus.rx_en); end
    if (bus.rd_data !== 8'h3C) begin n_fail++; $display("FAIL stop_data got %h want 3c", bus.rd_data); end
    if (bus.fifo_level !== 4'd1) begin n_fail++; $display("FAIL stop_level got %0d want 1", bus.fifo_level); end
    idle(3);
    n_cmp++;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL off_hold got %b want 0", bus.rx_en); end
    drain();
    bus.cfg_enable = 1'b1;
    idle(2);
    n_cmp++;
    if (bus.baud_div !== 32'd7777) begin n_fail++; $display("FAIL reenable_baud got %0d want 7777", bus.baud_div); end
  endtask

  task automatic test_random();
    bit d, e, r, c;
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 1) == 0);
      c = ($urandom_range(0, 31) == 0) && !(d && e);
      step(d, 8'($urandom), e, 1'b0, r, c);
      n_cmp += 5;
      if (bus.fifo_level !== 4'(q.size())) begin
        n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, bus.fifo_level, q.size());
      end
      if (bus.rd_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.rd_valid, q.size() != 0);
      end
      if (bus.fifo_full !== (q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_full[%0d] got %b want %b", i, bus.fifo_full, q.size() == DEPTH);
      end
      if (bus.overrun !== m_ovr) begin
        n_fail++; $display("FAIL rnd_ovr[%0d] got %b want %b", i, bus.overrun, m_ovr);
      end
      if (bus.err_cnt !== 8'(m_err)) begin
        n_fail++; $display("FAIL rnd_err[%0d] got %0d want %0d", i, bus.err_cnt, m_err);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (bus.rd_data !== q[0]) begin
          n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, bus.rd_data, q[0]);
        end
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    bus.cfg_baud_div = 32'd4;
    idle(3);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(120);
    n_cmp++;
    if (bus.timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", bus.timeout_irq); end
    idle(80);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    n_cmp++;
    if (bus.timeout_irq !== 1'b1) begin n_fail++; $display("FAIL to_set got %b want 1", bus.timeout_irq); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
`endif
    n_cmp++;
    if (bus.timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", bus.timeout_irq); end
    drain();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL mid_rx_en got %b want 0", bus.rx_en); end
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", bus.rd_valid); end
    if (bus.fifo_level !== 4'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", bus.fifo_level); end
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err got %0d want 0", bus.err_cnt); end
    if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", bus.rd_data); end
    if (bus.baud_div !== 32'd0) begin n_fail++; $display("FAIL mid_baud got %0d want 0", bus.baud_div); end
    q.delete();
    m_err = 0;
    m_ovr = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.rx_busy = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    idle(3);
    n_cmp++;
    if (bus.rx_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_off got %b want 0", bus.rx_en); end
  endtask

  initial begin
    m_ovr = 1'b0;
    m_err = 0;
    @(negedge clk);
    test_reset();
    test_enable();
    test_frame_error();
    test_overrun();
    test_divider_defer();
    test_stop();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
